// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned MEM_LAT_MIN = 1;
    localparam int unsigned MEM_LAT_MAX = 15;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    function automatic logic lat_ok(input int unsigned lat);
        return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that tracks the remaining memory latency of one access.
module mem_lat_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             is_one
);

    logic [CNT_W-1:0] count;

    // Saturates at zero so an idle counter never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign is_one = (count == CNT_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported fixed-latency memory between fetch and the memory stage,
// one access at a time, with done pulses, stall lines and a sticky protocol checker.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_cancel,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    if (!lat_ok(MEM_LAT)) begin : g_bad_lat
        $error("mem_arbiter: MEM_LAT must be within 1..15");
    end

    arb_state_t        state;
    logic              grant_id;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_wr;
    logic              drop;

    logic grant_d_c;
    logic grant_i_c;
    logic busy_c;
    logic cnt_is_one;
    logic i_keep_c;
    logic err_c;

    // Data side wins: its instruction is older than the one being fetched.
    assign grant_d_c = (state == IDLE) && d_req;
    assign grant_i_c = (state == IDLE) && !d_req && i_req && !i_cancel;
    assign busy_c    = (state == I_BUSY) || (state == D_BUSY);
    assign i_keep_c  = !drop && !i_cancel;

    always_comb begin
        err_c = 1'b0;
        if ((state == I_BUSY) && i_keep_c) begin
            err_c = !i_req || (i_addr != lat_addr);
        end else if (state == D_BUSY) begin
            err_c = !d_req || (d_addr != lat_addr) || (d_wr != lat_wr)
                  || (lat_wr && (d_wdata != lat_wdata));
        end
    end

    assign i_stall = i_req & ~i_done;
    assign d_stall = d_req & ~d_done;

    mem_lat_counter u_lat_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (grant_d_c | grant_i_c),
        .en       (busy_c),
        .load_val (CNT_W'(MEM_LAT)),
        .is_one   (cnt_is_one)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_id  <= REQ_I;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wr    <= 1'b0;
            drop      <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_done    <= 1'b0;
            i_rdata   <= '0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
            err       <= 1'b0;
        end else begin
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            if (err_c) begin
                err <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (grant_d_c) begin
                        grant_id  <= REQ_D;
                        lat_addr  <= d_addr;
                        lat_wdata <= d_wdata;
                        lat_wr    <= d_wr;
                        mem_en    <= 1'b1;
                        mem_wr    <= d_wr;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        state     <= D_BUSY;
                    end else if (grant_i_c) begin
                        grant_id  <= REQ_I;
                        lat_addr  <= i_addr;
                        lat_wdata <= '0;
                        lat_wr    <= 1'b0;
                        mem_en    <= 1'b1;
                        mem_addr  <= i_addr;
                        state     <= I_BUSY;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if ((state == I_BUSY) && i_cancel) begin
                        drop <= 1'b1;
                    end
                    // Last latency cycle: mem_rdata is valid now.
                    if (cnt_is_one) begin
                        state <= DONE;
                        if (grant_id == REQ_I) begin
                            if (i_keep_c) begin
                                i_rdata <= mem_rdata;
                                i_done  <= 1'b1;
                            end
                        end else begin
                            if (!lat_wr) begin
                                d_rdata <= mem_rdata;
                            end
                            d_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    drop  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
